// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: command codes, controller states and status-byte bit positions
package aes_spi_pkg;
  localparam logic [7:0] CMD_KEY  = 8'h10;
  localparam logic [7:0] CMD_ENC  = 8'h20;
  localparam logic [7:0] CMD_DEC  = 8'h30;
  localparam logic [7:0] CMD_READ = 8'h40;
  localparam int ST_BUSY = 7;
  localparam int ST_RV   = 6;
  localparam int ST_KV   = 5;
  localparam int ST_ERR  = 4;
  typedef enum logic [2:0] {IDLE, CMD, RX, RUN, TX, DRAIN} state_t;
endpackage

// File: rtl/aes_spi_ctrl_frame_shifter.sv
// frame_shifter: block-wide byte shift register with parallel load and byte-select readout
module frame_shifter #(
  parameter int NBYTES = 16,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [8*NBYTES-1:0]   i_data,
  input  logic [7:0]            i_byte,
  input  logic [CNT_W-1:0]      i_sel,
  output logic [8*NBYTES-1:0]   o_next,
  output logic [7:0]            o_byte
);
  logic [8*NBYTES-1:0] r_data;
  logic [CNT_W+2:0]    w_base;
  // o_next is the buffer as it will be once i_byte is shifted in
  assign o_next = {r_data[8*NBYTES-9:0], i_byte};
  // byte 0 is the most significant byte
  assign w_base = {CNT_W'(NBYTES-1) - i_sel, 3'b000};
  assign o_byte = r_data[w_base +: 8];
  always_ff @(posedge clk)
    if (reset) r_data <= '0;
    else if (i_load) r_data <= i_data;
    else if (i_shift) r_data <= o_next;
endmodule

// File: rtl/aes_spi_ctrl.sv
// aes_spi_ctrl: SPI frame controller that decodes commands, assembles key/data blocks,
// drives the AES core handshake and streams the captured result back out.
module aes_spi_ctrl
  import aes_spi_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  output logic [8*NBYTES-1:0]   aes_key,
  output logic [8*NBYTES-1:0]   aes_block,
  output logic                  aes_mode,
  output logic                  aes_start,
  input  logic                  aes_done,
  input  logic [8*NBYTES-1:0]   aes_result,
  output logic                  busy
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_sel;
  logic [7:0] r_cmd, r_tx_byte, w_status, w_sel_byte;
  logic [8*NBYTES-1:0] r_key, r_block, r_result, w_full;
  logic r_tx_load, r_mode, r_start, r_busy, r_rv, r_kv, r_err, r_fresh;
  logic w_err, w_byte_ok, w_last, w_to_rx, w_to_tx, w_load, w_shift, w_adv;

  assign w_byte_ok = rx_valid && !cs_n;
  assign w_last    = r_cnt == CNT_W'(NBYTES-1);
  assign w_sel     = r_cnt + 1'b1;
  assign w_to_rx   = rx_byte == CMD_KEY || ((rx_byte == CMD_ENC || rx_byte == CMD_DEC) && !r_busy);
  assign w_to_tx   = rx_byte == CMD_READ && !r_busy && r_rv;
  assign w_load    = r_state == CMD && w_next == TX;
  assign w_shift   = r_state == RX && w_byte_ok;
  assign w_adv     = w_byte_ok && (r_state == RX || r_state == TX);

  assign tx_byte   = r_tx_byte;
  assign tx_load   = r_tx_load;
  assign aes_key   = r_key;
  assign aes_block = r_block;
  assign aes_mode  = r_mode;
  assign aes_start = r_start;
  assign busy      = r_busy;

  frame_shifter #(.NBYTES(NBYTES), .CNT_W(CNT_W)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (r_result),
    .i_byte  (rx_byte),
    .i_sel   (w_sel),
    .o_next  (w_full),
    .o_byte  (w_sel_byte)
  );

  always_comb begin
    w_status = '0;
    w_status[ST_BUSY] = r_busy;
    w_status[ST_RV] = r_rv;
    w_status[ST_KV] = r_kv;
    w_status[ST_ERR] = r_err;
  end

  always_comb begin
    w_next = r_state;
    w_err = 1'b0;
    case (r_state)
      IDLE:  w_next = cs_n ? IDLE : CMD;
      CMD:
        if (cs_n) w_next = IDLE;
        else if (rx_valid) begin
          w_next = w_to_rx ? RX : w_to_tx ? TX : DRAIN;
          w_err = !w_to_rx && !w_to_tx;
        end
      RX:    w_next = cs_n ? IDLE : (rx_valid && w_last) ? ((r_cmd == CMD_KEY) ? DRAIN : RUN) : RX;
      RUN:   w_next = DRAIN;
      TX:    w_next = cs_n ? IDLE : (rx_valid && w_last) ? DRAIN : TX;
      DRAIN: w_next = cs_n ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_tx_byte <= '0;
      r_tx_load <= 1'b0;
      r_key     <= '0;
      r_block   <= '0;
      r_result  <= '0;
      r_mode    <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_rv      <= 1'b0;
      r_kv      <= 1'b0;
      r_err     <= 1'b0;
      r_fresh   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fresh <= w_next != r_state && (w_next == IDLE || w_next == DRAIN);
      r_cnt <= (r_state == IDLE) ? '0 : (w_adv && !w_last) ? r_cnt + 1'b1 : r_cnt;
      if (r_state == CMD && w_byte_ok) r_cmd <= rx_byte;
      r_start <= 1'b0;
      // status reload fires one cycle after DRAIN/IDLE entry so it carries the settled flags
      r_tx_load <= r_fresh;
      if (r_state != TX) r_tx_byte <= w_status;
      if (w_load) begin
        r_tx_load <= 1'b1;
        r_tx_byte <= r_result[8*NBYTES-1 -: 8];
      end
      if (r_state == TX && w_byte_ok && !w_last) begin
        r_tx_load <= 1'b1;
        r_tx_byte <= w_sel_byte;
      end
      if (w_err) r_err <= 1'b1;
      else if (r_state == TX && w_next == DRAIN) r_err <= 1'b0;
      if (r_state == RX && w_next == DRAIN) begin
        r_key <= w_full;
        r_kv  <= 1'b1;
      end
      if (r_state == RX && w_next == RUN) begin
        r_block <= w_full;
        r_mode  <= r_cmd == CMD_DEC;
        r_start <= 1'b1;
        r_busy  <= 1'b1;
        r_rv    <= 1'b0;
      end
      if (aes_done && r_busy) begin
        r_result <= aes_result;
        r_busy   <= 1'b0;
        r_rv     <= 1'b1;
      end
    end
endmodule
